base_awrr_arb: RTL and testbench

Weighted, transaction-aware round-robin arbiter: merges `ways` valid/ready source streams into one, granting each way up to its programmed weight of consecutive whole transactions before the turn passes on. A transaction is one or more beats; `i_h` keeps the grant locked until the last beat. Sits wherever multiple request streams converge on a shared channel. Registered 2-entry output buffer gives full throughput with no combinational `o_r`→`i_r` path.

---
 rtl/base_awrr_pkg.sv | 16 +
 rtl/base_awrr_if.sv | 27 ++
 rtl/base_awrr_obuf.sv | 47 ++++
 rtl/base_awrr_arb.sv | 135 +++++++++++++
 tb/tb_base_awrr_arb.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/base_awrr_pkg.sv
// Shared helpers for the weighted, transaction-aware round-robin arbiter.
package base_awrr_pkg;

    // Index width for a count of n items; never less than 1 bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    function automatic int unsigned next_way(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/base_awrr_if.sv
// Source-side and sink-side handshake bundle for base_awrr_arb.
interface base_awrr_if #(
    parameter int unsigned width    = 8,
    parameter int unsigned ways     = 4,
    parameter int unsigned wt_width = 4
);
    logic [ways*wt_width-1:0] i_wt;
    logic [ways-1:0]          i_v;
    logic [ways-1:0]          i_r;
    logic [ways-1:0]          i_h;
    logic [ways*width-1:0]    i_d;
    logic                     o_v;
    logic                     o_r;
    logic                     o_h;
    logic [ways-1:0]          o_s;
    logic [width-1:0]         o_d;

    modport master (
        output i_wt, i_v, i_h, i_d, o_r,
        input  i_r, o_v, o_h, o_s, o_d
    );

    modport slave (
        input  i_wt, i_v, i_h, i_d, o_r,
        output i_r, o_v, o_h, o_s, o_d
    );
endinterface

// File: rtl/base_awrr_obuf.sv
// Two-entry registered output FIFO; ready depends on occupancy only, never on pop.
module base_awrr_obuf #(
    parameter int unsigned dw = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [dw-1:0] push_data_i,
    output logic          ready_o,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [dw-1:0] head_o
);
    logic [dw-1:0] mem_q [2];
    logic          wr_q, rd_q;
    logic [1:0]    count_q, count_d;
    logic          do_push, do_pop;

    assign ready_o = (count_q != 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign head_o  = valid_o ? mem_q[rd_q] : '0;
    assign do_push = push_i & ready_o;
    assign do_pop  = pop_i & valid_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + 2'd1;
        if (!do_push && do_pop) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) rd_q <= ~rd_q;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/base_awrr_arb.sv
// Weighted round-robin arbiter: each way gets up to its weight of whole transactions per turn.
module base_awrr_arb
    import base_awrr_pkg::*;
#(
    parameter int unsigned width    = 8,
    parameter int unsigned ways     = 4,
    parameter int unsigned wt_width = 4
) (
    input logic        clk,
    input logic        reset,
    base_awrr_if.slave bus
);
    localparam int unsigned pw = clog2(ways);

    typedef struct packed {
        logic [ways-1:0]  s;
        logic             h;
        logic [width-1:0] d;
    } entry_t;

    localparam int unsigned ew = $bits(entry_t);

    logic [pw-1:0]       ptr_q, ptr_d;
    logic [wt_width-1:0] cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic [pw-1:0]       lock_way_q, lock_way_d;

    logic [wt_width-1:0] wt  [ways];
    logic [width-1:0]    dat [ways];

    logic                gnt_any;
    logic [pw-1:0]       gnt_idx;
    logic                buf_ready;
    logic                accept;
    logic [wt_width-1:0] eff;
    entry_t              push_e, head_e;

    // Way 0 occupies the most significant field of the packed buses.
    for (genvar w = 0; w < ways; w++) begin : g_unpack
        assign wt[w]  = bus.i_wt[(ways-1-w)*wt_width +: wt_width];
        assign dat[w] = bus.i_d[(ways-1-w)*width +: width];
    end

    always_comb begin
        logic [pw-1:0] cand;
        int unsigned   sum;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        sum     = 0;
        if (lock_q) begin
            // A locked way finishes its transaction even if its weight was zeroed.
            gnt_any = bus.i_v[lock_way_q];
            gnt_idx = lock_way_q;
        end else begin
            for (int unsigned k = 0; k < ways; k++) begin
                sum  = 32'(ptr_q) + k;
                cand = (sum >= ways) ? pw'(sum - ways) : pw'(sum);
                if (!gnt_any && bus.i_v[cand] && (wt[cand] != '0)) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign accept = gnt_any & buf_ready & reset;

    always_comb begin
        bus.i_r = '0;
        if (accept) bus.i_r[gnt_idx] = 1'b1;
    end

    assign eff = ((gnt_idx == ptr_q) && (cnt_q != '0)) ? cnt_q : wt[gnt_idx];

    always_comb begin
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        lock_way_d = lock_way_q;
        if (accept) begin
            if (bus.i_h[gnt_idx]) begin
                lock_d     = 1'b1;
                lock_way_d = gnt_idx;
            end else begin
                lock_d = 1'b0;
                if (eff <= wt_width'(1)) begin
                    ptr_d = pw'(next_way(32'(gnt_idx), ways));
                    cnt_d = '0;
                end else begin
                    ptr_d = gnt_idx;
                    cnt_d = eff - wt_width'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_way_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_way_q <= lock_way_d;
        end
    end

    always_comb begin
        push_e          = '0;
        push_e.s[gnt_idx] = 1'b1;
        push_e.h        = bus.i_h[gnt_idx];
        push_e.d        = dat[gnt_idx];
    end

    base_awrr_obuf #(
        .dw(ew)
    ) u_obuf (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept),
        .push_data_i(push_e),
        .ready_o    (buf_ready),
        .pop_i      (bus.o_r),
        .valid_o    (bus.o_v),
        .head_o     (head_e)
    );

    assign bus.o_s = head_e.s;
    assign bus.o_h = head_e.h;
    assign bus.o_d = head_e.d;
endmodule

// File: tb/tb_base_awrr_arb.sv
// Directed-vector bench for base_awrr_arb (ways=4, width=8, wt_width=4).
module tb_base_awrr_arb;
    logic clk = 1'b0;
    logic reset;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0] dat [4];

    always #5 clk = ~clk;

    base_awrr_if #(.width(8), .ways(4), .wt_width(4)) bus ();

    assign bus.i_d = {dat[0], dat[1], dat[2], dat[3]};

    base_awrr_arb #(
        .width   (8),
        .ways    (4),
        .wt_width(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Returns at a falling edge with reset just released.
    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b0;
        bus.i_v  = '0;
        bus.i_h  = '0;
        bus.o_r  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_wt = 16'h2130;
        bus.i_v  = 4'hf;
        bus.o_r  = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (bus.i_r !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_i_r: got %b want 0000", bus.i_r);
            end
            vectors++;
            if (bus.o_v !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_o_v: got %b want 0", bus.o_v);
            end
            vectors++;
            if ({bus.o_h, bus.o_s, bus.o_d} !== 13'd0) begin
                miscompares++;
                $display("FAIL reset_outs: got h=%b s=%b d=%h want zeros", bus.o_h, bus.o_s, bus.o_d);
            end
        end
    endtask

    task automatic test_rr();
        int seq [10] = '{0, 0, 1, 2, 2, 2, 0, 0, 1, 2};
        logic [3:0] exp_r;
        logic [7:0] exp_d;
        apply_reset();
        bus.i_wt = 16'h2130;
        dat      = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        bus.i_h  = '0;
        bus.o_r  = 1'b1;
        bus.i_v  = 4'hf;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_r = 4'b0001 << seq[k];
            vectors++;
            if (bus.i_r !== exp_r) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.i_r, exp_r);
            end
            if (k > 0) begin
                exp_r = 4'b0001 << seq[k-1];
                exp_d = 8'hA0 + 8'(seq[k-1]);
                vectors++;
                if (bus.o_v !== 1'b1 || bus.o_s !== exp_r || bus.o_d !== exp_d) begin
                    miscompares++;
                    $display("FAIL rr_out[%0d]: got v=%b s=%b d=%h want v=1 s=%b d=%h",
                             k, bus.o_v, bus.o_s, bus.o_d, exp_r, exp_d);
                end
            end
        end
        @(negedge clk);
        bus.i_v = '0;
    endtask

    task automatic test_hold();
        apply_reset();
        bus.i_wt = 16'h1111;
        bus.i_v  = 4'b0010;
        bus.i_h  = 4'b0010;
        dat      = '{8'h05, 8'h11, 8'h00, 8'h00};
        #1;
        vectors++;
        if (bus.i_r !== 4'b0010) begin
            miscompares++;
            $display("FAIL hold_b1_grant: got %b want 0010", bus.i_r);
        end
        @(negedge clk);
        bus.i_v = 4'b0011;
        dat[1]  = 8'h12;
        #1;
        vectors++;
        if (bus.i_r !== 4'b0010 || bus.o_s !== 4'b0010 || bus.o_d !== 8'h11 || bus.o_h !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_b2: got r=%b s=%b d=%h h=%b want r=0010 s=0010 d=11 h=1",
                     bus.i_r, bus.o_s, bus.o_d, bus.o_h);
        end
        @(negedge clk);
        dat[1]  = 8'h13;
        bus.i_h = 4'b0000;
        #1;
        vectors++;
        if (bus.i_r !== 4'b0010 || bus.o_d !== 8'h12 || bus.o_h !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_b3: got r=%b d=%h h=%b want r=0010 d=12 h=1",
                     bus.i_r, bus.o_d, bus.o_h);
        end
        @(negedge clk);
        bus.i_v = 4'b0001;
        #1;
        vectors++;
        if (bus.i_r !== 4'b0001 || bus.o_s !== 4'b0010 || bus.o_d !== 8'h13 || bus.o_h !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_next: got r=%b s=%b d=%h h=%b want r=0001 s=0010 d=13 h=0",
                     bus.i_r, bus.o_s, bus.o_d, bus.o_h);
        end
        @(negedge clk);
        bus.i_v = '0;
        #1;
        vectors++;
        if (bus.o_v !== 1'b1 || bus.o_s !== 4'b0001 || bus.o_d !== 8'h05) begin
            miscompares++;
            $display("FAIL hold_way0_out: got v=%b s=%b d=%h want v=1 s=0001 d=05",
                     bus.o_v, bus.o_s, bus.o_d);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_r [10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic [7:0] exp_d [10] = '{8'h00, 8'h30, 8'h30, 8'h30, 8'h30,
                                   8'h30, 8'h31, 8'h32, 8'h33, 8'h00};
        logic       exp_v [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        bus.i_wt = 16'h2130;
        bus.i_h  = '0;
        bus.o_r  = 1'b0;
        bus.i_v  = 4'b0001;
        dat[0]   = 8'h30;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            // Advance source data only after its previous beat was taken.
            if (k == 1) dat[0] = 8'h31;
            if (k == 2) dat[0] = 8'h32;
            if (k == 7) dat[0] = 8'h33;
            if (k == 8) bus.i_v = '0;
            if (k == 5) bus.o_r = 1'b1;
            #1;
            vectors++;
            if (bus.i_r !== exp_r[k] || bus.o_v !== exp_v[k] || bus.o_d !== exp_d[k]) begin
                miscompares++;
                $display("FAIL bp[%0d]: got r=%b v=%b d=%h want r=%b v=%b d=%h",
                         k, bus.i_r, bus.o_v, bus.o_d, exp_r[k], exp_v[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_single_way();
        apply_reset();
        bus.i_wt = 16'h2130;
        bus.i_h  = '0;
        bus.o_r  = 1'b1;
        bus.i_v  = 4'b0100;
        dat[2]   = 8'h40;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            dat[2] = 8'h40 + 8'(k);
            #1;
            vectors++;
            if (bus.i_r !== 4'b0100) begin
                miscompares++;
                $display("FAIL single_grant[%0d]: got %b want 0100", k, bus.i_r);
            end
            if (k > 0) begin
                vectors++;
                if (bus.o_v !== 1'b1 || bus.o_s !== 4'b0100 || bus.o_d !== 8'h40 + 8'(k - 1)) begin
                    miscompares++;
                    $display("FAIL single_out[%0d]: got v=%b s=%b d=%h want v=1 s=0100 d=%h",
                             k, bus.o_v, bus.o_s, bus.o_d, 8'h40 + 8'(k - 1));
                end
            end
        end
        @(negedge clk);
        bus.i_v = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.i_wt = 16'h1111;
        bus.i_v  = 4'b0010;
        bus.i_h  = 4'b0010;
        dat      = '{8'h66, 8'h55, 8'h00, 8'h00};
        #1;
        @(negedge clk);
        bus.i_v = 4'b0011;
        #1;
        vectors++;
        if (bus.i_r !== 4'b0010 || bus.o_s !== 4'b0010) begin
            miscompares++;
            $display("FAIL rmid_locked: got r=%b s=%b want r=0010 s=0010", bus.i_r, bus.o_s);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.o_v !== 1'b0 || bus.i_r !== 4'b0000) begin
            miscompares++;
            $display("FAIL rmid_in_reset: got v=%b r=%b want v=0 r=0000", bus.o_v, bus.i_r);
        end
        @(negedge clk);
        reset   = 1'b1;
        bus.i_h = '0;
        #1;
        vectors++;
        if (bus.i_r !== 4'b0001) begin
            miscompares++;
            $display("FAIL rmid_after: got %b want 0001", bus.i_r);
        end
        @(negedge clk);
        bus.i_v = '0;
        #1;
        vectors++;
        if (bus.o_v !== 1'b1 || bus.o_s !== 4'b0001 || bus.o_d !== 8'h66) begin
            miscompares++;
            $display("FAIL rmid_out: got v=%b s=%b d=%h want v=1 s=0001 d=66",
                     bus.o_v, bus.o_s, bus.o_d);
        end
    endtask

    task automatic test_wt_change();
        int seq [9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
        logic [3:0] exp_r;
        apply_reset();
        bus.i_wt = 16'h2100;
        bus.i_h  = '0;
        bus.o_r  = 1'b1;
        bus.i_v  = 4'b0011;
        dat      = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) bus.i_wt = 16'h4100;
            #1;
            exp_r = 4'b0001 << seq[k];
            vectors++;
            if (bus.i_r !== exp_r) begin
                miscompares++;
                $display("FAIL wt_grant[%0d]: got %b want %b", k, bus.i_r, exp_r);
            end
        end
        @(negedge clk);
        bus.i_v = '0;
    endtask

    initial begin
        reset    = 1'b0;
        bus.i_v  = '0;
        bus.i_h  = '0;
        bus.i_wt = '0;
        bus.o_r  = 1'b0;
        dat      = '{8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
        test_rr();
        test_hold();
        test_backpressure();
        test_single_way();
        test_reset_mid();
        test_wt_change();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
